memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 118 +++++++++++
 tb/tb_memory_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-port word memory behind a request/ready handshake with a programmable
// number of wait states; out-of-range accesses complete with error and no side effects.
module memory_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request,
  input  logic        write,
  input  logic [15:31] memory_address,
  input  logic [0:31]  memory_data_out,
  output logic [0:31]  memory_data_in,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int         WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;

  logic [31:0] mem [WORDS];

  // Flatten the ascending-range ports so MSB stays at the left-hand index.
  logic [16:0] addr_in;
  logic [31:0] wdata_in;
  assign addr_in  = memory_address;
  assign wdata_in = memory_data_out;

  logic                  oor;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  mem_we;
  assign oor    = (req_q.addr >> DEPTH_LOG2) != 17'd0;
  assign idx    = req_q.addr[DEPTH_LOG2-1:0];
  assign mem_we = (state_q == RESPOND) && req_q.we && !oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          req_d = '{we: write, addr: addr_in, wdata: wdata_in};
          if (WS == 4'd0) begin
            state_d = RESPOND;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESPOND;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        ready_d = 1'b1;
        error_d = oor;
        if (!req_q.we) rdata_d = oor ? 32'd0 : mem[idx];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Storage is never reset; an async reset forces IDLE first, which masks mem_we.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= req_q.wdata;
  end

  assign memory_data_in = rdata_q;
  assign ready          = ready_q;
  assign error          = error_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed plus randomized checks of memory_responder against an array-based
// reference memory, using a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_memory_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [15:31] addr = '0;
  logic [0:31]  wd = '0;
  logic [0:31]  rd;
  logic        rdy, err, bsy;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [15:31] addr0 = '0;
  logic [0:31]  wd0 = '0;
  logic [0:31]  rd0;
  logic        rdy0, err0, bsy0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_LOG2(12), .WAIT_STATES(WS)) dut (
    .clock(clk), .reset(rst), .request(req), .write(we),
    .memory_address(addr), .memory_data_out(wd), .memory_data_in(rd),
    .ready(rdy), .error(err), .busy(bsy)
  );

  memory_responder #(.DEPTH_LOG2(12), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(rst), .request(req0), .write(we0),
    .memory_address(addr0), .memory_data_out(wd0), .memory_data_in(rd0),
    .ready(rdy0), .error(err0), .busy(bsy0)
  );

  int tests = 0;
  int fails = 0;

  bit [31:0]   ref_mem  [4096];
  bit [31:0]   ref_mem0 [4096];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One access on the WS=2 instance; garbage is driven on the inputs while it is busy.
  task automatic access(input bit w, input logic [16:0] a, input logic [31:0] d, input string tag);
    int lat;
    bit out_of_range;
    logic [31:0] exp_rd;
    out_of_range = (a[16:12] != 5'd0);
    if (w) begin
      if (!out_of_range) ref_mem[a[11:0]] = d;
      exp_rd = last_rd;
    end else begin
      exp_rd = out_of_range ? 32'd0 : ref_mem[a[11:0]];
    end
    last_rd = exp_rd;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wd = d;
    @(negedge clk);
    lat = 0;
    while (!rdy && lat < 20) begin
      check({tag, " busy"}, 32'(bsy), 32'd1);
      req = 1'($urandom); we = 1'($urandom); addr = 17'($urandom); wd = $urandom;
      @(negedge clk);
      lat++;
    end
    req = 1'b0; we = 1'b0;
    check({tag, " latency"}, lat, WS + 1);
    check({tag, " error"}, 32'(err), 32'(out_of_range));
    check({tag, " data"}, rd, exp_rd);
    @(negedge clk);
    check({tag, " ready pulse"}, 32'(rdy), 32'd0);
    check({tag, " data hold"}, rd, exp_rd);
  endtask

  initial begin
    int k;
    logic [16:0] ra;
    // reset state
    repeat (2) @(negedge clk);
    check("rst ready", 32'(rdy), 32'd0);
    check("rst error", 32'(err), 32'd0);
    check("rst busy", 32'(bsy), 32'd0);
    check("rst data", rd, 32'd0);
    rst = 1'b0;

    // write then read back, first request right after reset
    access(1'b1, 17'h00010, 32'hDEADBEEF, "wr10");
    access(1'b0, 17'h00010, 32'h0, "rd10");
    // out-of-range read, then in-range read unaffected
    access(1'b0, 17'h1F000, 32'h0, "rd_oor");
    access(1'b0, 17'h00000, 32'h0, "rd0");
    access(1'b1, 17'h1F010, 32'hCAFEF00D, "wr_oor");
    access(1'b0, 17'h00010, 32'h0, "rd10_after_oor");

    // reset in WAIT of a write aborts it
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 17'h00020; wd = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    check("abort busy", 32'(bsy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort ready", 32'(rdy), 32'd0);
    check("abort error", 32'(err), 32'd0);
    check("abort busy0", 32'(bsy), 32'd0);
    check("abort data", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'd0;
    access(1'b0, 17'h00020, 32'h0, "rd20_after_abort");
    access(1'b0, 17'h00010, 32'h0, "rd10_after_reset");

    // zero-wait instance: fill 1..3, then stream reads with request held high
    for (int a = 1; a <= 3; a++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 17'(a); wd0 = $urandom;
      ref_mem0[a] = wd0;
      @(negedge clk);
      req0 = 1'b0;
      @(negedge clk);
      check("ws0 wr ready", 32'(rdy0), 32'd1);
    end
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 17'd1;
    k = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check("ws0 gap ready", 32'(rdy0), 32'd0);
        check("ws0 gap busy", 32'(bsy0), 32'd1);
      end else begin
        check("ws0 ready", 32'(rdy0), 32'd1);
        check("ws0 data", rd0, ref_mem0[k]);
        k++;
        if (k <= 3) addr0 = 17'(k);
        else req0 = 1'b0;
      end
    end

    // randomized traffic on a small address set plus occasional out-of-range
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) ra = {5'($urandom_range(1, 31)), 12'($urandom)};
      else ra = 17'($urandom_range(0, 15));
      access(1'($urandom_range(0, 1)), ra, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
